// File: rtl/ram_readback_checker.sv
`default_nettype none
// ============================================================================
// Module      : ram_readback_checker
// Description : Sweeps every address of a memory read port after a start
//               pulse and checks each word against the address pattern
//               (data == address, zero-extended). Reports pass/fail, the
//               mismatch count and the first failing address/data.
//               Supports combinational (SYNC_READ=0) or registered
//               (SYNC_READ=1) memory reads.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_readback_checker #(
  parameter int DEPTH     = 16,
  parameter int ADDR_BITS = 4,
  parameter int WIDTH     = 32,
  parameter int SYNC_READ = 0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  output logic                 rd_en,
  output logic [ADDR_BITS-1:0] rd_addr,
  input  logic [WIDTH-1:0]     rd_data,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ADDR_BITS:0]   err_count,
  output logic [ADDR_BITS-1:0] first_err_addr,
  output logic [WIDTH-1:0]     first_err_data
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SWEEP = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_BITS-1:0] c_LAST_ADDR = ADDR_BITS'(DEPTH - 1);

  state_t                 r_state;
  logic                   r_rd_en;
  logic [ADDR_BITS-1:0]   r_rd_addr;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_pass;
  logic [ADDR_BITS:0]     r_err_count;
  logic [ADDR_BITS-1:0]   r_first_err_addr;
  logic [WIDTH-1:0]       r_first_err_data;

  // Address/valid of the word whose data is on rd_data this cycle
  logic                   w_chk_vld;
  logic [ADDR_BITS-1:0]   w_chk_addr;
  logic                   w_mismatch;
  logic                   w_first;
  logic [ADDR_BITS:0]     w_err_next;
  logic                   w_last;

  if (SYNC_READ != 0) begin : g_sync_read
    logic                 r_dvld;
    logic [ADDR_BITS-1:0] r_daddr;

    // Delay the issued address one stage to line up with registered read data
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        r_dvld  <= 1'b0;
        r_daddr <= '0;
      end else begin
        r_dvld  <= r_rd_en;
        r_daddr <= r_rd_addr;
      end
    end

    assign w_chk_vld  = r_dvld;
    assign w_chk_addr = r_daddr;
  end else begin : g_comb_read
    assign w_chk_vld  = (r_state == S_SWEEP);
    assign w_chk_addr = r_rd_addr;
  end

  assign w_mismatch = w_chk_vld && (rd_data != WIDTH'(w_chk_addr));
  assign w_first    = w_mismatch && (r_err_count == '0);
  assign w_err_next = r_err_count + {{ADDR_BITS{1'b0}}, w_mismatch};
  assign w_last     = (r_rd_addr == c_LAST_ADDR);

  // Sweep controller: issues reads, accumulates mismatches, publishes results
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state          <= S_IDLE;
      r_rd_en          <= 1'b0;
      r_rd_addr        <= '0;
      r_busy           <= 1'b0;
      r_done           <= 1'b0;
      r_pass           <= 1'b0;
      r_err_count      <= '0;
      r_first_err_addr <= '0;
      r_first_err_data <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state          <= S_SWEEP;
            r_rd_en          <= 1'b1;
            r_rd_addr        <= '0;
            r_busy           <= 1'b1;
            r_done           <= 1'b0;
            r_pass           <= 1'b0;
            r_err_count      <= '0;
            r_first_err_addr <= '0;
            r_first_err_data <= '0;
          end
        end

        S_SWEEP: begin
          if (w_mismatch) begin
            r_err_count <= w_err_next;
          end
          if (w_first) begin
            r_first_err_addr <= w_chk_addr;
            r_first_err_data <= rd_data;
          end
          r_rd_addr <= r_rd_addr + 1'b1;
          if (w_last) begin
            r_rd_en   <= 1'b0;
            r_rd_addr <= '0;
            if (SYNC_READ != 0) begin
              // Last word is still in flight through the memory register
              r_state <= S_DRAIN;
            end else begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_pass  <= (w_err_next == '0);
            end
          end
        end

        S_DRAIN: begin
          if (w_mismatch) begin
            r_err_count <= w_err_next;
          end
          if (w_first) begin
            r_first_err_addr <= w_chk_addr;
            r_first_err_data <= rd_data;
          end
          r_state <= S_DONE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_pass  <= (w_err_next == '0);
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign rd_en          = r_rd_en;
  assign rd_addr        = r_rd_addr;
  assign busy           = r_busy;
  assign done           = r_done;
  assign pass           = r_pass;
  assign err_count      = r_err_count;
  assign first_err_addr = r_first_err_addr;
  assign first_err_data = r_first_err_data;

endmodule
`default_nettype wire

// File: tb/tb_ram_readback_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_readback_checker
// Description : Scoreboard bench for ram_readback_checker. One instance uses
//               a combinational-read memory, the other a registered-read
//               memory. Expected results are queued at each start; monitors
//               pop and compare when done rises.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_readback_checker;

  logic        clock = 1'b0;
  logic        reset;
  logic        start0, start1;

  logic        rd_en0, busy0, done0, pass0;
  logic [3:0]  rd_addr0, fea0;
  logic [31:0] rd_data0, fed0;
  logic [4:0]  err0;

  logic        rd_en1, busy1, done1, pass1;
  logic [3:0]  rd_addr1, fea1;
  logic [31:0] rd_data1 = 32'h0;
  logic [31:0] fed1;
  logic [4:0]  err1;

  logic [31:0] mem0 [16];
  logic [31:0] mem1 [16];

  typedef struct {
    int          done_cyc;
    logic [4:0]  err;
    logic [3:0]  fa;
    logic [31:0] fd;
    logic        pass;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  logic pd0   = 1'b0;
  logic pd1   = 1'b0;

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Combinational-read memory
  assign rd_data0 = mem0[rd_addr0];

  // Registered-read memory
  always @(posedge clock) if (rd_en1) rd_data1 <= mem1[rd_addr1];

  ram_readback_checker #(.DEPTH(16), .ADDR_BITS(4), .WIDTH(32), .SYNC_READ(0)) dut0 (
    .clock(clock), .reset(reset), .start(start0),
    .rd_en(rd_en0), .rd_addr(rd_addr0), .rd_data(rd_data0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
    .first_err_addr(fea0), .first_err_data(fed0)
  );

  ram_readback_checker #(.DEPTH(16), .ADDR_BITS(4), .WIDTH(32), .SYNC_READ(1)) dut1 (
    .clock(clock), .reset(reset), .start(start1),
    .rd_en(rd_en1), .rd_addr(rd_addr1), .rd_data(rd_data1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .first_err_addr(fea1), .first_err_data(fed1)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Monitors: compare results on the rising edge of done
  always @(negedge clock) begin
    if (done0 && !pd0) begin
      if (q0.size() == 0) begin
        total++; bad++;
        $display("FAIL dut0 unexpected done actual=1 required=0");
      end else begin
        e0 = q0.pop_front();
        chk("dut0 done edge", cyc, e0.done_cyc);
        chk("dut0 err_count", err0, e0.err);
        chk("dut0 first_err_addr", fea0, e0.fa);
        chk("dut0 first_err_data", fed0, e0.fd);
        chk("dut0 pass", pass0, e0.pass);
        chk("dut0 busy at done", busy0, 0);
        chk("dut0 rd_en at done", rd_en0, 0);
      end
    end
    pd0 <= done0;
  end

  always @(negedge clock) begin
    if (done1 && !pd1) begin
      if (q1.size() == 0) begin
        total++; bad++;
        $display("FAIL dut1 unexpected done actual=1 required=0");
      end else begin
        e1 = q1.pop_front();
        chk("dut1 done edge", cyc, e1.done_cyc);
        chk("dut1 err_count", err1, e1.err);
        chk("dut1 first_err_addr", fea1, e1.fa);
        chk("dut1 first_err_data", fed1, e1.fd);
        chk("dut1 pass", pass1, e1.pass);
        chk("dut1 busy at done", busy1, 0);
      end
    end
    pd1 <= done1;
  end

  task automatic ident0();
    for (int i = 0; i < 16; i++) mem0[i] = i;
  endtask

  task automatic ident1();
    for (int i = 0; i < 16; i++) mem1[i] = i;
  endtask

  // Pulse start and queue the expected result; done follows after 16 / 17 edges
  task automatic go0(input logic [4:0] err, input logic [3:0] fa, input logic [31:0] fd, input logic ps);
    exp_t e;
    @(negedge clock);
    e.done_cyc = cyc + 1 + 16;
    e.err = err; e.fa = fa; e.fd = fd; e.pass = ps;
    q0.push_back(e);
    start0 = 1'b1;
    @(negedge clock);
    start0 = 1'b0;
  endtask

  task automatic go1(input logic [4:0] err, input logic [3:0] fa, input logic [31:0] fd, input logic ps);
    exp_t e;
    @(negedge clock);
    e.done_cyc = cyc + 1 + 17;
    e.err = err; e.fa = fa; e.fd = fd; e.pass = ps;
    q1.push_back(e);
    start1 = 1'b1;
    @(negedge clock);
    start1 = 1'b0;
  endtask

  task automatic wait0();
    for (int i = 0; i < 40 && q0.size() != 0; i++) @(negedge clock);
    chk("dut0 pending results after timeout", q0.size(), 0);
    q0.delete();
  endtask

  task automatic wait1();
    for (int i = 0; i < 40 && q1.size() != 0; i++) @(negedge clock);
    chk("dut1 pending results after timeout", q1.size(), 0);
    q1.delete();
  endtask

  task automatic wait_addr0(input logic [3:0] a);
    for (int i = 0; i < 20 && rd_addr0 != a; i++) @(negedge clock);
    chk("dut0 reached target rd_addr", rd_addr0, a);
  endtask

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset  = 1'b1;
    start0 = 1'b0;
    start1 = 1'b0;
    ident0();
    ident1();
    repeat (3) @(negedge clock);
    chk("reset rd_en", rd_en0, 0);
    chk("reset rd_addr", rd_addr0, 0);
    chk("reset busy", busy0, 0);
    chk("reset done", done0, 0);
    chk("reset pass", pass0, 0);
    chk("reset err_count", err0, 0);
    chk("reset first_err_addr", fea0, 0);
    chk("reset first_err_data", fed0, 0);
    chk("dut1 reset busy", busy1, 0);
    chk("dut1 reset done", done1, 0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // Clean memory
    ident0();
    go0(5'd0, 4'd0, 32'h0, 1'b1);
    chk("dut0 busy during sweep", busy0, 1);
    chk("dut0 rd_en during sweep", rd_en0, 1);
    wait0();

    // Single corrupted word
    mem0[5] = 32'hDEAD;
    go0(5'd1, 4'd5, 32'hDEAD, 1'b0);
    wait0();

    // Two corrupted words, first captured
    ident0();
    mem0[3] = 32'h0;
    mem0[9] = 32'hFFFF_FFFF;
    go0(5'd2, 4'd3, 32'h0, 1'b0);
    wait0();

    // Every word wrong (address 0 included)
    for (int i = 0; i < 16; i++) mem0[i] = 32'hFFFF_FFFF;
    go0(5'd16, 4'd0, 32'hFFFF_FFFF, 1'b0);
    wait0();

    // Restart after done clears results; start while busy is ignored
    ident0();
    go0(5'd0, 4'd0, 32'h0, 1'b1);
    wait_addr0(4'd4);
    start0 = 1'b1;
    @(negedge clock);
    start0 = 1'b0;
    chk("dut0 busy after mid-sweep start", busy0, 1);
    chk("dut0 rd_addr continues after mid-sweep start", rd_addr0, 5);
    wait0();

    // Another sweep after done
    mem0[5] = 32'h7;
    go0(5'd1, 4'd5, 32'h7, 1'b0);
    wait0();

    // Asynchronous reset mid-sweep
    ident0();
    mem0[2] = 32'h55;
    go0(5'd0, 4'd0, 32'h0, 1'b0);
    wait_addr0(4'd7);
    chk("dut0 err_count before reset", err0, 1);
    #2 reset = 1'b1;
    #1;
    chk("async reset rd_en", rd_en0, 0);
    chk("async reset rd_addr", rd_addr0, 0);
    chk("async reset busy", busy0, 0);
    chk("async reset done", done0, 0);
    chk("async reset pass", pass0, 0);
    chk("async reset err_count", err0, 0);
    chk("async reset first_err_addr", fea0, 0);
    chk("async reset first_err_data", fed0, 0);
    q0.delete();
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    mem0[2]  = 32'h2;
    mem0[12] = 32'h100;
    go0(5'd1, 4'd12, 32'h100, 1'b0);
    wait0();

    // Registered-read instance: clean, then last word corrupted (exercises drain)
    ident1();
    go1(5'd0, 4'd0, 32'h0, 1'b1);
    wait1();
    mem1[15] = 32'h1;
    go1(5'd1, 4'd15, 32'h1, 1'b0);
    wait1();

    repeat (2) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ram_readback_checker.md
Name: ram_readback_checker

Overview:
Read-side companion to the address-pattern memory writer. On a start pulse it sweeps every address of a RAMMEM-style memory through the read port and checks each word against the writer's pattern: data equals the address, zero-extended to WIDTH. It reports pass/fail, the number of mismatches, and the first failing address and data. It sits beside the memory instance as a built-in self-check for the write path.

Parameters:
DEPTH, 16, number of words swept; must equal 2^ADDR_BITS.
ADDR_BITS, 4, read address width.
WIDTH, 32, data width; must be >= ADDR_BITS.
SYNC_READ, 0, 0 = combinational read (data valid in the same cycle as the address); 1 = registered read (data valid one cycle after rd_en/rd_addr).

Ports:
clock  input  1  single clock; all state updates on the posedge.
reset  input  1  asynchronous, active-high reset; clears all state immediately.
start  input  1  one-cycle request to begin a sweep; honoured only when not busy.
rd_en  output 1  read enable to the memory read port.
rd_addr  output ADDR_BITS  read address to the memory.
rd_data  input WIDTH  read data from the memory.
busy  output 1  sweep in progress.
done  output 1  sweep finished; held until the next accepted start.
pass  output 1  valid while done=1; 1 when err_count==0.
err_count  output ADDR_BITS+1  number of mismatching words in the last sweep (0..DEPTH).
first_err_addr  output ADDR_BITS  address of the first mismatch; 0 if none.
first_err_data  output WIDTH  data read at first_err_addr; 0 if none.

Behaviour:
- Reset (async, any state): state=IDLE; rd_en=0; rd_addr=0; busy=0; done=0; pass=0; err_count=0; first_err_addr=0; first_err_data=0. A reset during a sweep aborts it with no partial results kept.
- FSM states: IDLE, SWEEP, DRAIN (used only when SYNC_READ=1), DONE.
- IDLE/DONE + start=1 at an edge: go to SWEEP. Same edge sets rd_addr=0, rd_en=1, busy=1, done=0, pass=0, and clears err_count, first_err_addr and first_err_data.
- SWEEP: rd_en=1. rd_addr increments by 1 at each edge.
  - SYNC_READ=0: at each edge, compare rd_data against {zeros, rd_addr}.
  - SYNC_READ=1: the address is delayed one stage with a valid bit; at each edge, compare rd_data against the delayed address when the valid bit is set.
- Mismatch: err_count += 1. If this is the first mismatch of the sweep, capture first_err_addr and first_err_data. err_count cannot exceed DEPTH, so no saturation is needed.
- End of SWEEP: at the edge where rd_addr==DEPTH-1 is checked or issued, rd_en drops to 0 and rd_addr wraps to 0.
  - SYNC_READ=0: go directly to DONE.
  - SYNC_READ=1: go to DRAIN for one cycle to compare the last word, then to DONE.
- DONE: busy=0, done=1, pass=(err_count==0). All results hold until the next accepted start.
- Latency: done rises DEPTH edges after the start edge when SYNC_READ=0, and DEPTH+1 edges after when SYNC_READ=1.
- start while busy (SWEEP or DRAIN): ignored; the sweep continues unchanged.
- start coincident with reset: reset wins.
- rd_data is ignored whenever rd_en=0 and no delayed read is pending.

Test Plan:
- Memory preloaded with word[a]=a, SYNC_READ=0, start pulse -> rd_addr steps 0..15 over 16 cycles; done=1 and pass=1 at edge 16; err_count=0, first_err_addr=0, first_err_data=0.
- Same preload but word[5]=32'hDEAD -> err_count=1, pass=0, first_err_addr=5, first_err_data=32'hDEAD.
- word[3]=32'h0 and word[9]=32'hFFFF_FFFF -> err_count=2, first_err_addr=3, first_err_data=0; with every word set to 32'hFFFF_FFFF -> err_count=16.
- start re-pulsed at rd_addr=4 mid-sweep -> no restart; done still at edge 16 and results unchanged; a second start after done clears the results and repeats the sweep.
- reset asserted asynchronously while rd_addr=7 -> all outputs 0 immediately, without waiting for a clock edge; a start after reset deasserts gives a correct full sweep.
- SYNC_READ=1 model with a one-cycle registered read, word[15]=32'h1 -> DRAIN state is exercised; done at edge 17; err_count=1, first_err_addr=15, first_err_data=1.
